// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Shared constants for the fifo_buffer slice.
//   DEF_ABITS  - default address width (depth = 2**DEF_ABITS entries)
//   DEF_DBITS  - default data word width
//   DEF_PTR_W  - default pointer width (address width plus one wrap bit)
//   ptr_width  - pointer width for an arbitrary address width
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_ABITS = 7;
    localparam int DEF_DBITS = 64;

    // The extra pointer bit distinguishes "full" from "empty" when the
    // low address bits of the two pointers coincide.
    function automatic int ptr_width(input int abits);
        return abits + 1;
    endfunction

    localparam int DEF_PTR_W = DEF_ABITS + 1;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
//
// Simple dual-port storage array for fifo_buffer: one synchronous write port
// and one asynchronous (combinational) read port. Contents are not reset.
//
// Ports:
//   clock    in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   [abits-1:0] write address
//   wr_data  in   [dbits-1:0] write data
//   rd_addr  in   [abits-1:0] read address
//   rd_data  out  [dbits-1:0] read data (combinational from rd_addr)
// -----------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int abits = DEF_ABITS,
    parameter int dbits = DEF_DBITS
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [abits-1:0] wr_addr,
    input  logic [dbits-1:0] wr_data,
    input  logic [abits-1:0] rd_addr,
    output logic [dbits-1:0] rd_data
);

    localparam int DEPTH = 1 << abits;

    logic [dbits-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read gives first-word-fall-through at the FIFO output.
    assign rd_data = mem[rd_addr];

endmodule : fifo_ram

// File: rtl/fifo_buffer.sv
// -----------------------------------------------------------------------------
// fifo_buffer
//
// Synchronous circular-buffer FIFO, 2**abits words of dbits width, with
// valid/ready handshakes on both sides and first-word-fall-through output.
//
// Optional feature macro: FIFO_COUNT_EN
//   When defined, an occupancy output `count` [abits:0] is added.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   din            in   [dbits-1:0] write data
//   s_axis_tvalid  in   producer has valid din
//   s_axis_tready  out  FIFO not full
//   dout           out  [dbits-1:0] head-of-queue data (zero when empty)
//   m_axis_tvalid  out  FIFO not empty
//   m_axis_tready  in   consumer accepts dout
//   count          out  [abits:0] occupancy (FIFO_COUNT_EN only)
// -----------------------------------------------------------------------------
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int abits = DEF_ABITS,
    parameter int dbits = DEF_DBITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dbits-1:0] din,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [dbits-1:0] dout,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
`ifdef FIFO_COUNT_EN
    ,
    output logic [abits:0]   count
`endif
);

    localparam int              PW      = ptr_width(abits);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [dbits-1:0] rd_data;

    // Flags come only from registered pointers, so ready/valid never
    // depend combinationally on the handshake inputs.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[abits-1:0] == rd_ptr[abits-1:0]) &&
                   (wr_ptr[abits] != rd_ptr[abits]);

    assign s_axis_tready = !full;
    assign m_axis_tvalid = !empty;

    // Gating by the registered flags means a pop on a full FIFO does not
    // open a push slot in the same cycle, and a push into an empty FIFO
    // is not bypassed to the output.
    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    fifo_ram #(
        .abits (abits),
        .dbits (dbits)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr[abits-1:0]),
        .wr_data (din),
        .rd_addr (rd_ptr[abits-1:0]),
        .rd_data (rd_data)
    );

    // Stale RAM contents are masked so an empty FIFO always shows zero.
    assign dout = empty ? '0 : rd_data;

`ifdef FIFO_COUNT_EN
    // Modular subtraction of the wrap-flagged pointers yields 0..2**abits.
    assign count = wr_ptr - rd_ptr;
`endif

endmodule : fifo_buffer

// File: tb/tb_fifo_buffer.sv
// -----------------------------------------------------------------------------
// tb_fifo_buffer
//
// Self-checking bench for fifo_buffer (default parameters). Inputs are driven
// and outputs sampled at the falling clock edge; the DUT updates on the
// rising edge in between. A queue holds the words the FIFO should contain.
// -----------------------------------------------------------------------------
module tb_fifo_buffer;

    localparam int ABITS = 7;
    localparam int DBITS = 64;
    localparam int DEPTH = 1 << ABITS;

    logic             clock;
    logic             reset;
    logic [DBITS-1:0] din;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [DBITS-1:0] dout;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
`ifdef FIFO_COUNT_EN
    logic [ABITS:0]   count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DBITS-1:0] exp_q [$];

    fifo_buffer #(
        .abits (ABITS),
        .dbits (DBITS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .din           (din),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .dout          (dout),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef FIFO_COUNT_EN
        ,
        .count         (count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset         = 1'b0;
        din           = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clock);
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tready: got %b expected 1", s_axis_tready);
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
        n_checks++;
        if (dout !== '0) begin
            n_fail++;
            $display("FAIL reset_dout: got %h expected 0", dout);
        end
`ifdef FIFO_COUNT_EN
        n_checks++;
        if (count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
`endif
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("FAIL post_reset: got tready=%b tvalid=%b dout=%h expected 1 0 0",
                     s_axis_tready, m_axis_tvalid, dout);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_burst_write();
        logic [DBITS-1:0] words [6];
        words[0] = 64'h00000001_00000001;
        words[1] = 64'h00000001_00000002;
        words[2] = 64'h00000001_00000004;
        words[3] = 64'h00000002_00000001;
        words[4] = 64'h00000002_00000002;
        words[5] = 64'h00000002_00000004;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (s_axis_tready !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_tready[%0d]: got %b expected 1", i, s_axis_tready);
            end
            din           = words[i];
            s_axis_tvalid = 1'b1;
            exp_q.push_back(words[i]);
            @(negedge clock);
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || dout !== words[0]) begin
                n_fail++;
                $display("FAIL burst_head[%0d]: got tvalid=%b dout=%h expected 1 %h",
                         i, m_axis_tvalid, dout, words[0]);
            end
        end
        s_axis_tvalid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (dout !== words[0]) begin
            n_fail++;
            $display("FAIL burst_hold: got %h expected %h", dout, words[0]);
        end
`ifdef FIFO_COUNT_EN
        n_checks++;
        if (count !== 8'd6) begin
            n_fail++;
            $display("FAIL burst_count: got %0d expected 6", count);
        end
`endif
    endtask

    // ------------------------------------------------------------------
    task automatic test_drain();
        logic [DBITS-1:0] exp;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < DEPTH + 4 && exp_q.size() > 0; i++) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || dout !== exp) begin
                n_fail++;
                $display("FAIL drain[%0d]: got tvalid=%b dout=%h expected 1 %h",
                         i, m_axis_tvalid, dout, exp);
            end
            @(negedge clock);
        end
        m_axis_tready = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || dout !== '0 || s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: got tvalid=%b dout=%h tready=%b expected 0 0 1",
                     m_axis_tvalid, dout, s_axis_tready);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        logic [DBITS-1:0] exp;
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (s_axis_tready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_tready[%0d]: got %b expected 1", i, s_axis_tready);
            end
            din           = DBITS'(i);
            s_axis_tvalid = 1'b1;
            exp_q.push_back(DBITS'(i));
            @(negedge clock);
        end
        n_checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_flags: got tready=%b tvalid=%b expected 0 1",
                     s_axis_tready, m_axis_tvalid);
        end
`ifdef FIFO_COUNT_EN
        n_checks++;
        if (count !== 8'd128) begin
            n_fail++;
            $display("FAIL full_count: got %0d expected 128", count);
        end
`endif
        // Overflow attempt: must be refused.
        din = 64'hDEAD;
        repeat (2) @(negedge clock);
        n_checks++;
        if (s_axis_tready !== 1'b0 || dout !== 64'd0) begin
            n_fail++;
            $display("FAIL overflow: got tready=%b dout=%h expected 0 0",
                     s_axis_tready, dout);
        end
        // Pop and push together while full: only the pop happens.
        din           = 64'hBEEF;
        m_axis_tready = 1'b1;
        exp = exp_q.pop_front();
        n_checks++;
        if (dout !== exp) begin
            n_fail++;
            $display("FAIL full_pop_head: got %h expected %h", dout, exp);
        end
        @(negedge clock);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        n_checks++;
        if (s_axis_tready !== 1'b1 || dout !== exp_q[0]) begin
            n_fail++;
            $display("FAIL full_pop_push: got tready=%b dout=%h expected 1 %h",
                     s_axis_tready, dout, exp_q[0]);
        end
`ifdef FIFO_COUNT_EN
        n_checks++;
        if (count !== 8'd127) begin
            n_fail++;
            $display("FAIL full_pop_count: got %0d expected 127", count);
        end
`endif
        test_drain();
    endtask

    // ------------------------------------------------------------------
    task automatic test_empty_no_bypass();
        // Push and ready together on an empty FIFO: no pop this cycle.
        din           = 64'h0123_4567_89AB_CDEF;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        exp_q.push_back(din);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL nobypass_pre: got tvalid=%b expected 0", m_axis_tvalid);
        end
        @(negedge clock);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || dout !== exp_q[0]) begin
            n_fail++;
            $display("FAIL nobypass_post: got tvalid=%b dout=%h expected 1 %h",
                     m_axis_tvalid, dout, exp_q[0]);
        end
        test_drain();
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap_concurrent();
        logic [DBITS-1:0] exp;
        logic [DBITS-1:0] next_val;
        int               err;
        next_val      = 64'h1000;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din           = next_val;
            s_axis_tvalid = 1'b1;
            exp_q.push_back(next_val);
            next_val++;
            @(negedge clock);
        end
        m_axis_tready = 1'b1;
        err = 0;
        for (int i = 0; i < 300; i++) begin
            din = next_val;
            exp = exp_q.pop_front();
            exp_q.push_back(next_val);
            next_val++;
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b1 || dout !== exp) begin
                n_fail++;
                err++;
                if (err <= 5)
                    $display("FAIL wrap[%0d]: got tvalid=%b tready=%b dout=%h expected 1 1 %h",
                             i, m_axis_tvalid, s_axis_tready, dout, exp);
            end
            @(negedge clock);
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        n_checks++;
        if (exp_q.size() != 3 || dout !== exp_q[0]) begin
            n_fail++;
            $display("FAIL wrap_hold: got dout=%h expected %h", dout, exp_q[0]);
        end
`ifdef FIFO_COUNT_EN
        n_checks++;
        if (count !== 8'd3) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d expected 3", count);
        end
`endif
        test_drain();
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din           = 64'hA000 + DBITS'(i);
            s_axis_tvalid = 1'b1;
            exp_q.push_back(din);
            @(negedge clock);
        end
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || dout !== exp_q[0]) begin
            n_fail++;
            $display("FAIL prereset_head: got tvalid=%b dout=%h expected 1 %h",
                     m_axis_tvalid, dout, exp_q[0]);
        end
        // Assert reset between edges; effect must be immediate.
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || dout !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got tvalid=%b tready=%b dout=%h expected 0 1 0",
                     m_axis_tvalid, s_axis_tready, dout);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
        din           = 64'h5555_AAAA_0000_FFFF;
        s_axis_tvalid = 1'b1;
        exp_q.push_back(din);
        @(negedge clock);
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || dout !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_readback: got tvalid=%b dout=%h expected 1 %h",
                     m_axis_tvalid, dout, exp_q[0]);
        end
`ifdef FIFO_COUNT_EN
        n_checks++;
        if (count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_readback_count: got %0d expected 1", count);
        end
`endif
        test_drain();
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_burst_write();
        test_drain();
        test_full();
        test_empty_no_bypass();
        test_wrap_concurrent();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_buffer
